// File: rtl/rv_boot_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM state encoding and stream framing constants.
package rv_boot_pkg;

  // Loader FSM states. CHECK is only ever entered when the trailing
  // checksum byte is part of the stream.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  // Bytes assembled into one 32-bit instruction word.
  localparam int BYTES_PER_WORD = 4;
  // Bytes in the little-endian word-count header.
  localparam int LEN_BYTES      = 2;
  localparam int LEN_W          = 8 * LEN_BYTES;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage : rv_boot_pkg

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer: each accepted byte lands in the lane
// selected by the byte index; word_full_o flags the byte completing a word.
module imem_word_packer
  import rv_boot_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        shift_i,
  input  logic [7:0]                  byte_i,
  output logic [8*BYTES_PER_WORD-1:0] word_o,
  output logic                        word_full_o
);

  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;

  // Next lane contents and byte index; index wraps after the last lane.
  // NOTE: every _d gets a default before any condition so no latch is inferred.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (shift_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + 1'b1;
    end
  end

  // Lane and index registers.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = shift_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));

endmodule : imem_word_packer

// File: rtl/imem_loader.sv
// Boot-time program loader: consumes a little-endian byte stream
// (16-bit word count, then instruction words), writes the words into
// instruction memory from address 0 and holds the CPU in reset until the
// image is complete. Defining IMEM_LOADER_CHECKSUM_EN adds a trailing
// mod-256 payload checksum byte verified in the CHECK state.
module imem_loader
  import rv_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  // Length comparisons are done one bit wider so a full-capacity image
  // (2^ADDR_W words) is representable.
  localparam int                CMP_W    = LEN_W + 1;
  localparam logic [CMP_W-1:0]  CAPACITY = CMP_W'(1) << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_LOAD = ST_CHECK;
`else
  localparam state_e ST_AFTER_LOAD = ST_DONE;
`endif

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [ADDR_W:0]    count_q, count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  logic               xfer;
  logic               pack_clear;
  logic               pack_shift;
  logic               pack_full;
  logic [31:0]        pack_word;
  logic [LEN_W-1:0]   len_full;

  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (pack_clear),
    .shift_i     (pack_shift),
    .byte_i      (byte_data),
    .word_o      (pack_word),
    .word_full_o (pack_full)
  );

  // State, header length, written-word count (and checksum) registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      length_q <= '0;
      count_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      count_q  <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    count_d    = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    pack_clear = 1'b0;

    byte_ready = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
    busy       = state_q inside {ST_LEN0, ST_LEN1, ST_DATA, ST_WRITE, ST_CHECK};
    done       = (state_q == ST_DONE);
    error      = (state_q == ST_ERR);
    imem_we    = (state_q == ST_WRITE);
    imem_waddr = count_q[ADDR_W-1:0];
    imem_wdata = pack_word;
    word_count = count_q;
    // The CPU leaves reset only in DONE, and is pulled back the moment a
    // new load is requested.
    cpu_rst    = !((state_q == ST_DONE) && !start);

    xfer       = byte_valid && byte_ready;
    pack_shift = xfer && (state_q == ST_DATA);
    len_full   = {byte_data, length_q[7:0]};

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          count_d    = '0;
          pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      ST_LEN0: begin
        if (xfer) begin
          length_d[7:0] = byte_data;
          state_d       = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (xfer) begin
          length_d = len_full;
          if (len_full == '0)                    state_d = ST_AFTER_LOAD;
          else if (CMP_W'(len_full) > CAPACITY)  state_d = ST_ERR;
          else                                   state_d = ST_DATA;
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer) sum_d = sum_q + byte_data;
`endif
        if (pack_full) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        if (CMP_W'(count_d) == CMP_W'(length_q)) state_d = ST_AFTER_LOAD;
        else                                     state_d = ST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_d = (byte_data == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=8). A behavioural model
// derives the expected memory writes and final status from the byte image.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int          checks = 0;
  int          errors = 0;
  wr_t         wr_q[$];
  logic [31:0] words_q[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Record every memory write seen by the instruction memory.
  always @(negedge clk) begin
    if (imem_we) wr_q.push_back('{a: imem_waddr, d: imem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 0);
    check({tag, "_imem_we"},    32'(imem_we),    0);
    check({tag, "_waddr"},      32'(imem_waddr), 0);
    check({tag, "_wdata"},      imem_wdata,      0);
    check({tag, "_cpu_rst"},    32'(cpu_rst),    1);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_done"},       32'(done),       0);
    check({tag, "_error"},      32'(error),      0);
    check({tag, "_word_count"}, 32'(word_count), 0);
  endtask

  task automatic fill_words(input int n);
    words_q.delete();
    repeat (n) words_q.push_back($urandom);
  endtask

  // Called and returns at posedge+1; presents one byte until it is taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      int g = $urandom_range(0, 2);
      byte_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n          = 0;
    @(negedge clk);
    while (!byte_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("ready_timeout", 32'(byte_ready), 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    check("start_cpu_rst", 32'(cpu_rst), 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One complete load of words_q[0..len-1] with header len; the model
  // expects in-order writes from address 0, and a failure if the length
  // exceeds capacity or the checksum byte is corrupted.
  task automatic do_load(input string tag, input int len, input bit gap,
                         input int stall_at, input bit start_mid, input bit bad_cks);
    logic [7:0] sum = 8'd0;
    int         bi  = 0;
    int         n;
    int         exp_writes;
    bit         exp_err;
    exp_writes = (len <= CAP) ? len : 0;
    exp_err    = (len > CAP) || bad_cks;
    wr_q.delete();
    pulse_start();
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (len <= CAP) begin
      for (int w = 0; w < len; w++) begin
        for (int b = 0; b < 4; b++) begin
          logic [7:0] by;
          by = words_q[w][8*b +: 8];
          if (bi == stall_at) begin
            repeat (7) begin
              @(negedge clk);
              check({tag, "_stall_no_we"}, 32'(imem_we), 0);
              @(posedge clk); #1;
            end
          end
          if (start_mid && bi == 1) begin
            start = 1'b1;
            @(negedge clk);
            check({tag, "_busy_at_start"}, 32'(busy), 1);
            @(posedge clk); #1;
            start = 1'b0;
          end
          send_byte(by, gap);
          sum = sum + by;
          bi++;
          if (b == 3) begin
            @(negedge clk);
            check({tag, "_we_latency"},     32'(imem_we),    1);
            check({tag, "_ready_in_write"}, 32'(byte_ready), 0);
            @(posedge clk); #1;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_cks ? 8'(sum + 8'd1) : sum, gap);
`endif
    end
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish_busy"}, 32'(busy),       0);
    check({tag, "_done"},        32'(done),       exp_err ? 0 : 1);
    check({tag, "_error"},       32'(error),      exp_err ? 1 : 0);
    check({tag, "_cpu_rst"},     32'(cpu_rst),    exp_err ? 1 : 0);
    check({tag, "_word_count"},  32'(word_count), 32'(exp_writes));
    check({tag, "_n_writes"},    32'(wr_q.size()), 32'(exp_writes));
    for (int i = 0; i < exp_writes && i < wr_q.size(); i++) begin
      check({tag, "_wr_addr"}, 32'(wr_q[i].a), 32'(i));
      check({tag, "_wr_data"}, wr_q[i].d,      words_q[i]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word image, continuous stream.
    words_q.delete();
    words_q.push_back(32'h0050_0013);
    words_q.push_back(32'h00A0_0093);
    do_load("two_words", 2, 1'b0, -1, 1'b0, 1'b0);

    // Seven idle cycles between the 2nd and 3rd payload byte.
    fill_words(1);
    do_load("stall", 1, 1'b0, 2, 1'b0, 1'b0);

    // Oversize header, then recovery with a valid one-word image.
    do_load("oversize", 257, 1'b0, -1, 1'b0, 1'b0);
    fill_words(1);
    do_load("after_err", 1, 1'b1, -1, 1'b0, 1'b0);

    // Empty image.
    do_load("len_zero", 0, 1'b0, -1, 1'b0, 1'b0);

    // Full-capacity image with random gaps.
    fill_words(CAP);
    do_load("len_full", CAP, 1'b1, -1, 1'b0, 1'b0);

    // Random small images; one receives a start pulse mid-load.
    for (int k = 0; k < 4; k++) begin
      int len = $urandom_range(1, 6);
      fill_words(len);
      do_load("random", len, 1'b1, -1, (k == 1), 1'b0);
    end

    // Reset after five payload bytes, then a fresh load from address 0.
    fill_words(3);
    wr_q.delete();
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(words_q[i/4][8*(i%4) +: 8], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_words(1);
    do_load("after_rst", 1, 1'b0, -1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Payload 01 02 03 04 sums to 0x0A; the bad case sends 0x0B.
    words_q.delete();
    words_q.push_back(32'h0403_0201);
    do_load("cks_good", 1, 1'b0, -1, 1'b0, 1'b0);
    do_load("cks_bad",  1, 1'b0, -1, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the fetch stage's instruction memory.
- Accepts a little-endian byte stream (valid/ready) carrying a 16-bit word count followed by the instruction words.
- Assembles 32-bit instructions and writes them sequentially into instruction memory.
- Holds the CPU in reset via cpu_rst until the image is fully and correctly loaded.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- byte_valid  in  1  upstream byte available
- byte_data  in  8  upstream byte
- byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_waddr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- cpu_rst  out  1  reset to fetch/register file; high until load succeeds
- busy  out  1  load in progress
- done  out  1  image loaded; level, held until next start or rst
- error  out  1  load failed; level, held until next start or rst
- word_count  out  ADDR_W+1  words written in current/last load

Behaviour:
- Reset (async): state IDLE; byte_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0, word_count=0; byte shift register and byte index cleared.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CHECK (feature only), DONE, ERR.
- IDLE/DONE/ERR: start -> LEN0; clears done, error, word_count; cpu_rst forced 1 in the same cycle start is sampled.
- LEN0: on transfer, latch length[7:0] -> LEN1.
- LEN1: on transfer, latch length[15:8]. Transitions:
  - length==0 -> DONE (or CHECK if feature enabled).
  - length > 2^ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA: on each transfer, shift byte into word at lane byte_index (first byte = bits 7:0). On the 4th byte -> WRITE.
- WRITE: exactly one cycle:
  - imem_we=1, imem_waddr=word_count[ADDR_W-1:0], imem_wdata=assembled word.
  - word_count increments at the end of the cycle.
  - If incremented count == length -> DONE (or CHECK); else -> DATA.
- Latency: the 4th byte accepted at edge k produces imem_we high in cycle k+1; byte_ready=0 during WRITE, giving a maximum throughput of 4 bytes per 5 cycles.
- byte_ready=1 only in LEN0, LEN1, DATA, CHECK; 0 in IDLE, WRITE, DONE, ERR. Bytes offered while byte_ready=0 are not consumed and not lost upstream.
- busy=1 in LEN0..CHECK.
- DONE: done=1, cpu_rst=0.
- ERR: error=1, cpu_rst=1.
- start while busy: ignored.
- byte_valid low stalls any state indefinitely; no timeout.
- rst mid-load: immediate return to reset values; partially written memory contents are not undone.
- A length of exactly 2^ADDR_W is legal. The last write lands at address 2^ADDR_W-1, and word_count reaches 2^ADDR_W without wrap (hence its ADDR_W+1 width).

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) accumulates every payload byte; length bytes are excluded and the sum is cleared on start.
  - After the last WRITE, or after LEN1 when length==0, the state goes to CHECK, which accepts one byte.
  - Byte equals sum -> DONE. Byte differs -> ERR, with cpu_rst held at 1.
- Undefined: CHECK state and the sum register are absent; the stream carries no trailing byte.

Decomposition:
- Shared package rv_boot_pkg holds:
  - state encoding enum (IDLE..ERR)
  - constant BYTES_PER_WORD=4
  - constant LEN_BYTES=2
- One natural sub-module: imem_word_packer, containing the byte-lane shift register, byte index, and a word_full flag.

Test Plan:
- Load 2 words, stream 02 00 | 13 00 50 00 | 93 00 A0 00, byte_valid continuous -> imem_we pulses at addr 0 with 0x00500013 and at addr 1 with 0x00A00093; done=1, cpu_rst=0, word_count=2.
- Backpressure/stall: drop byte_valid for 7 cycles between bytes 2 and 3 of a word -> no write until the 4th byte arrives; imem_we asserted exactly once, one cycle after the 4th transfer; byte_ready=0 during the WRITE cycle.
- Oversize: ADDR_W=8, length 0x0101 -> ERR after LEN1 with no imem_we; error=1, cpu_rst=1; a subsequent start plus valid 1-word stream -> done=1.
- Boundary: length 0 -> DONE without writes, word_count=0. Length 256 -> last write at addr 0xFF, word_count=256.
- rst pulsed mid-DATA after 5 payload bytes -> all outputs at reset values next cycle; a new start loads from addr 0.
- With IMEM_LOADER_CHECKSUM_EN: 1 word 01 02 03 04 then 0x0A -> done=1. The same stream followed by 0x0B -> error=1, cpu_rst=1.
